// File: rtl/cpu_mem_bridge_if.sv
// Core-side fetch/data handshakes plus the single-port RAM bus of cpu_mem_bridge.
// slave = bridge view, master = core + RAM view.
interface cpu_mem_bridge_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [31:0]       PC;
    logic              Inst_Req_Valid;
    logic              Inst_Req_Ack;
    logic [31:0]       Instruction;
    logic              Inst_Valid;
    logic              Inst_Ack;
    logic [31:0]       Address;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Write_data;
    logic [3:0]        Write_strb;
    logic              Mem_Req_Ack;
    logic [31:0]       Read_data;
    logic              Read_data_Valid;
    logic              Read_data_Ack;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wstrb;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ack, Address, MemRead, MemWrite,
               Write_data, Write_strb, Read_data_Ack, ram_rdata,
        output Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data,
               Read_data_Valid, ram_en, ram_addr, ram_wstrb, ram_wdata
    );

    modport master (
        output PC, Inst_Req_Valid, Inst_Ack, Address, MemRead, MemWrite,
               Write_data, Write_strb, Read_data_Ack, ram_rdata,
        input  Inst_Req_Ack, Instruction, Inst_Valid, Mem_Req_Ack, Read_data,
               Read_data_Valid, ram_en, ram_addr, ram_wstrb, ram_wdata
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Serialises core fetch and data requests onto one synchronous RAM with a programmable wait.
// Define MEM_BRIDGE_PERF_EN to add the inst_stall_cnt / data_stall_cnt stall counters.
module cpu_mem_bridge #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    cpu_mem_bridge_if.slave    bus
`ifdef MEM_BRIDGE_PERF_EN
    ,
    output logic [31:0]        inst_stall_cnt,
    output logic [31:0]        data_stall_cnt
`endif
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {IDLE, WAIT, RAM_RD, RAM_CAP, RESP, RAM_WR} state_t;
    typedef enum logic [1:0] {K_INST, K_DRD, K_DWR} kind_t;

    typedef struct packed {
        kind_t             kind;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [31:0]      inst_q, rdata_q;
    logic             inst_valid_q, rd_valid_q;
    logic             ram_en_q;
    logic [3:0]       ram_wstrb_q;
    logic [31:0]      ram_wdata_q;
    logic             data_req, inst_ack_c, mem_ack_c, resp_done;
    logic             unused_bits;

    assign data_req    = bus.MemRead | bus.MemWrite;
    assign unused_bits = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0],
                           bus.Address[31:ADDR_W+2], bus.Address[1:0]};

    // Next-state, request capture and handshake acks
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        mem_ack_c  = 1'b0;
        inst_ack_c = 1'b0;
        resp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                mem_ack_c  = data_req;
                inst_ack_c = bus.Inst_Req_Valid & ~data_req;
                if (mem_ack_c) begin
                    req_d.kind = bus.MemWrite ? K_DWR : K_DRD;
                    req_d.addr = bus.Address[ADDR_W+1:2];
                end else if (inst_ack_c) begin
                    req_d.kind = K_INST;
                    req_d.addr = bus.PC[ADDR_W+1:2];
                end
                if (mem_ack_c | inst_ack_c) begin
                    req_d.wdata = bus.Write_data;
                    req_d.wstrb = bus.Write_strb;
                    cnt_d       = CNT_W'(LATENCY);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = (req_q.kind == K_DWR) ? RAM_WR : RAM_RD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RAM_RD:  state_d = RAM_CAP;
            RAM_CAP: state_d = RESP;
            RESP: begin
                resp_done = (req_q.kind == K_INST) ? bus.Inst_Ack : bus.Read_data_Ack;
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            RAM_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Registered response data/valids and RAM strobes, decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q       <= '0;
            rdata_q      <= '0;
            inst_valid_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_wstrb_q  <= '0;
            ram_wdata_q  <= '0;
        end else begin
            if (state_q == RAM_CAP) begin
                if (req_q.kind == K_INST) begin
                    inst_q <= bus.ram_rdata;
                end else begin
                    rdata_q <= bus.ram_rdata;
                end
            end
            inst_valid_q <= (state_d == RESP) && (req_q.kind == K_INST);
            rd_valid_q   <= (state_d == RESP) && (req_q.kind != K_INST);
            ram_en_q     <= (state_d == RAM_RD) || (state_d == RAM_WR);
            ram_wstrb_q  <= (state_d == RAM_WR) ? req_q.wstrb : 4'h0;
            ram_wdata_q  <= (state_d == RAM_WR) ? req_q.wdata : 32'h0;
        end
    end

    // Acks are forced low while reset is asserted so every output reads 0
    assign bus.Inst_Req_Ack    = inst_ack_c & rst;
    assign bus.Mem_Req_Ack     = mem_ack_c & rst;
    assign bus.Instruction     = inst_q;
    assign bus.Inst_Valid      = inst_valid_q;
    assign bus.Read_data       = rdata_q;
    assign bus.Read_data_Valid = rd_valid_q;
    assign bus.ram_en          = ram_en_q;
    assign bus.ram_addr        = req_q.addr;
    assign bus.ram_wstrb       = ram_wstrb_q;
    assign bus.ram_wdata       = ram_wdata_q;

`ifdef MEM_BRIDGE_PERF_EN
    logic inst_busy, data_busy, inst_stall, data_stall;
    logic [31:0] inst_cnt_q, data_cnt_q;

    assign inst_busy  = (state_q != IDLE) && (req_q.kind == K_INST);
    assign data_busy  = (state_q != IDLE) && (req_q.kind != K_INST);
    assign inst_stall = (bus.Inst_Req_Valid | inst_busy) & ~(inst_valid_q & bus.Inst_Ack);
    assign data_stall = (data_req | data_busy) & ~(rd_valid_q & bus.Read_data_Ack);

    // Stall counters wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            if (inst_stall) inst_cnt_q <= inst_cnt_q + 32'd1;
            if (data_stall) data_cnt_q <= data_cnt_q + 32'd1;
        end
    end

    assign inst_stall_cnt = inst_cnt_q;
    assign data_stall_cnt = data_cnt_q;
`endif
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: LATENCY=2 instance for the main sequences,
// LATENCY=0 instance for the short-latency timing.
module tb_cpu_mem_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem1 [0:4095];

    cpu_mem_bridge_if #(.ADDR_W(12)) bus0 ();
    cpu_mem_bridge_if #(.ADDR_W(12)) bus1 ();

`ifdef MEM_BRIDGE_PERF_EN
    logic [31:0] inst_cnt0, data_cnt0, inst_cnt1, data_cnt1;
`endif

    cpu_mem_bridge #(.ADDR_W(12), .LATENCY(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef MEM_BRIDGE_PERF_EN
        ,
        .inst_stall_cnt (inst_cnt0),
        .data_stall_cnt (data_cnt0)
`endif
    );

    cpu_mem_bridge #(.ADDR_W(12), .LATENCY(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
`ifdef MEM_BRIDGE_PERF_EN
        ,
        .inst_stall_cnt (inst_cnt1),
        .data_stall_cnt (data_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous RAM models with 1-cycle read latency and byte enables
    always @(posedge clk) begin
        if (bus0.ram_en) begin
            if (bus0.ram_wstrb == 4'h0) bus0.ram_rdata <= mem0[bus0.ram_addr];
            else for (int b = 0; b < 4; b++)
                if (bus0.ram_wstrb[b]) mem0[bus0.ram_addr][8*b +: 8] <= bus0.ram_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (bus1.ram_en) begin
            if (bus1.ram_wstrb == 4'h0) bus1.ram_rdata <= mem1[bus1.ram_addr];
            else for (int b = 0; b < 4; b++)
                if (bus1.ram_wstrb[b]) mem1[bus1.ram_addr][8*b +: 8] <= bus1.ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.PC = '0; bus0.Inst_Req_Valid = 0; bus0.Inst_Ack = 0; bus0.Address = '0;
        bus0.MemRead = 0; bus0.MemWrite = 0; bus0.Write_data = '0; bus0.Write_strb = '0;
        bus0.Read_data_Ack = 0;
        bus1.PC = '0; bus1.Inst_Req_Valid = 0; bus1.Inst_Ack = 0; bus1.Address = '0;
        bus1.MemRead = 0; bus1.MemWrite = 0; bus1.Write_data = '0; bus1.Write_strb = '0;
        bus1.Read_data_Ack = 0;
    endtask

    int en_at, n_en, got, blocked;
`ifdef MEM_BRIDGE_PERF_EN
    logic [31:0] c0, d0;
`endif

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem0[4]  = 32'h00500093;
        mem0[8]  = 32'h11223344;
        mem0[16] = 32'h55555555;
        mem1[5]  = 32'hCAFEF00D;
        idle_inputs();

        #2;
        check("rst_inst_valid", 32'(bus0.Inst_Valid), 32'h0);
        check("rst_ram_en",     32'(bus0.ram_en),     32'h0);
        check("rst_instr",      bus0.Instruction,     32'h0);
        #10 rst = 1'b1;

        // Fetch at LATENCY=2
        step();
        bus0.PC = 32'h10; bus0.Inst_Req_Valid = 1;
        @(negedge clk);
        check("fetch_req_ack", 32'(bus0.Inst_Req_Ack), 32'h1);
        check("fetch_mem_ack", 32'(bus0.Mem_Req_Ack),  32'h0);
        step();
        bus0.Inst_Req_Valid = 0;
        en_at = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.ram_en) begin
                en_at = k;
                check("fetch_ram_addr",  32'(bus0.ram_addr),  32'h4);
                check("fetch_ram_wstrb", 32'(bus0.ram_wstrb), 32'h0);
            end
            if (k == 5) check("fetch_valid_early", 32'(bus0.Inst_Valid), 32'h0);
        end
        check("fetch_ram_en_cycle", 32'(en_at), 32'd4);
        check("fetch_valid", 32'(bus0.Inst_Valid), 32'h1);
        check("fetch_data",  bus0.Instruction, 32'h00500093);

        // Backpressure: 5 cycles without Inst_Ack, ack on the 6th
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin step(); @(negedge clk); end
            check("bp_valid", 32'(bus0.Inst_Valid), 32'h1);
            check("bp_data",  bus0.Instruction, 32'h00500093);
        end
        step();
        bus0.Inst_Ack = 1;
        @(negedge clk);
        check("bp_valid_at_ack", 32'(bus0.Inst_Valid), 32'h1);
        step();
        bus0.Inst_Ack = 0;

        // Byte store right after the fetch returns to IDLE
        bus0.Address = 32'h20; bus0.MemWrite = 1;
        bus0.Write_strb = 4'b0100; bus0.Write_data = 32'h00AB0000;
        @(negedge clk);
        check("bp_valid_dropped", 32'(bus0.Inst_Valid),   32'h0);
        check("st_mem_ack",       32'(bus0.Mem_Req_Ack),  32'h1);
        check("st_inst_ack",      32'(bus0.Inst_Req_Ack), 32'h0);
        step();
        bus0.MemWrite = 0; bus0.Write_strb = '0; bus0.Write_data = '0;
        n_en = 0; en_at = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.ram_en) begin
                n_en++; en_at = k;
                check("st_ram_addr",  32'(bus0.ram_addr),  32'h8);
                check("st_ram_wstrb", 32'(bus0.ram_wstrb), 32'h4);
                check("st_ram_wdata", bus0.ram_wdata, 32'h00AB0000);
            end
        end
        check("st_en_count", 32'(n_en),  32'd1);
        check("st_en_cycle", 32'(en_at), 32'd4);
        check("st_mem_word", mem0[8], 32'h11AB3344);

        // Priority: load and fetch together at T+LATENCY+3 after the store
        bus0.Address = 32'h20; bus0.MemRead = 1;
        bus0.PC = 32'h10; bus0.Inst_Req_Valid = 1;
        #1;
        check("prio_mem_ack",  32'(bus0.Mem_Req_Ack),  32'h1);
        check("prio_inst_ack", 32'(bus0.Inst_Req_Ack), 32'h0);
        step();
        bus0.MemRead = 0;
        blocked = 0; got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.Inst_Req_Ack) blocked = 1;
            if (bus0.Read_data_Valid) got = k;
        end
        check("prio_fetch_blocked", 32'(blocked), 32'h0);
        check("ld_latency", 32'(got), 32'd6);
        check("ld_data", bus0.Read_data, 32'h11AB3344);
        bus0.Read_data_Ack = 1;
        step();
        bus0.Read_data_Ack = 0;
        check("ld_valid_dropped",   32'(bus0.Read_data_Valid), 32'h0);
        check("prio_fetch_granted", 32'(bus0.Inst_Req_Ack),    32'h1);
        step();
        bus0.Inst_Req_Valid = 0;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.Inst_Valid) got = k;
        end
        check("prio_fetch_latency", 32'(got), 32'd6);
        check("prio_fetch_data", bus0.Instruction, 32'h00500093);
        bus0.Inst_Ack = 1;
        step();
        bus0.Inst_Ack = 0;

        // Reset during the WAIT of a full-word write
        bus0.Address = 32'h40; bus0.MemWrite = 1;
        bus0.Write_strb = 4'hF; bus0.Write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("rwr_mem_ack", 32'(bus0.Mem_Req_Ack), 32'h1);
        step();
        bus0.MemWrite = 0; bus0.Write_strb = '0; bus0.Write_data = '0;
        step();
        rst = 1'b0;
        #1;
        check("rwr_ram_en",     32'(bus0.ram_en),          32'h0);
        check("rwr_ram_addr",   32'(bus0.ram_addr),        32'h0);
        check("rwr_ram_wdata",  bus0.ram_wdata,            32'h0);
        check("rwr_instr",      bus0.Instruction,          32'h0);
        check("rwr_read_data",  bus0.Read_data,            32'h0);
        check("rwr_rd_valid",   32'(bus0.Read_data_Valid), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) step();
        check("rwr_no_write", mem0[16], 32'h55555555);
        bus0.PC = 32'h10; bus0.Inst_Req_Valid = 1;
        @(negedge clk);
        check("rwr_fetch_ack", 32'(bus0.Inst_Req_Ack), 32'h1);
        step();
        bus0.Inst_Req_Valid = 0;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.Inst_Valid) got = k;
        end
        check("rwr_fetch_latency", 32'(got), 32'd6);
        check("rwr_fetch_data", bus0.Instruction, 32'h00500093);
        bus0.Inst_Ack = 1;
        step();
        bus0.Inst_Ack = 0;

`ifdef MEM_BRIDGE_PERF_EN
        // One fetch acked in its second RESP cycle: T..T+6 are stall cycles
        step();
        c0 = inst_cnt0; d0 = data_cnt0;
        bus0.PC = 32'h10; bus0.Inst_Req_Valid = 1;
        step();
        bus0.Inst_Req_Valid = 0;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus0.Inst_Valid) got = k;
        end
        step();
        bus0.Inst_Ack = 1;
        step();
        bus0.Inst_Ack = 0;
        check("perf_inst_delta", inst_cnt0 - c0, 32'd7);
        check("perf_data_delta", data_cnt0 - d0, 32'd0);
`endif

        // LATENCY=0 instance: fetch valid at T+4, write strobe at T+2
        step();
        bus1.PC = 32'h14; bus1.Inst_Req_Valid = 1;
        @(negedge clk);
        check("l0_fetch_ack", 32'(bus1.Inst_Req_Ack), 32'h1);
        step();
        bus1.Inst_Req_Valid = 0;
        got = 0;
        for (int k = 1; k <= 20 && got == 0; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus1.Inst_Valid) got = k;
        end
        check("l0_fetch_latency", 32'(got), 32'd4);
        check("l0_fetch_data", bus1.Instruction, 32'hCAFEF00D);
        bus1.Inst_Ack = 1;
        step();
        bus1.Inst_Ack = 0;
        bus1.Address = 32'h30; bus1.MemWrite = 1;
        bus1.Write_strb = 4'hF; bus1.Write_data = 32'h0BADF00D;
        @(negedge clk);
        check("l0_wr_ack", 32'(bus1.Mem_Req_Ack), 32'h1);
        step();
        bus1.MemWrite = 0; bus1.Write_strb = '0; bus1.Write_data = '0;
        en_at = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) step();
            @(negedge clk);
            if (bus1.ram_en) en_at = k;
        end
        check("l0_wr_en_cycle", 32'(en_at), 32'd2);
        check("l0_wr_mem", mem1[12], 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard stop in case a sequence loses sync with the DUT
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Downstream of the multi-cycle RISC-V core; terminates its instruction-fetch and data-memory handshake channels.
- Serialises both channels onto one single-port synchronous RAM (1-cycle read latency) and inserts a programmable wait to emulate slow memory.
- Owns all request/response ack and valid generation that the core's FSM waits on.

Parameters:
- ADDR_W, 12, RAM word-address width; word index = byte address[ADDR_W+1:2], upper bits ignored.
- LATENCY, 2, extra wait cycles per access (0..255).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- PC  in  32  fetch byte address.
- Inst_Req_Valid  in  1  fetch request.
- Inst_Req_Ack  out  1  fetch request accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  Instruction valid.
- Inst_Ack  in  1  core consumes Instruction.
- Address  in  32  data byte address (word aligned).
- MemRead  in  1  data read request.
- MemWrite  in  1  data write request.
- Write_data  in  32  store data.
- Write_strb  in  4  byte enables.
- Mem_Req_Ack  out  1  data request accepted.
- Read_data  out  32  load word.
- Read_data_Valid  out  1  Read_data valid.
- Read_data_Ack  in  1  core consumes Read_data.
- ram_en  out  1  RAM access strobe.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wstrb  out  4  write byte enables (0 = read).
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  valid the cycle after ram_en with ram_wstrb=0.

Behaviour:
- Reset (rst=0, async): state IDLE, wait counter 0, every output 0, response registers 0. Reset mid-access abandons it with no RAM write.
- States: IDLE, WAIT, RAM_RD, RAM_CAP, RESP, RAM_WR.
- IDLE: Mem_Req_Ack = MemRead|MemWrite (combinational). Inst_Req_Ack = Inst_Req_Valid & ~(MemRead|MemWrite). Data has priority; both acks are never high in the same cycle. Acks are 0 in every other state.
- Accept edge T: latch kind (inst / data-read / data-write), word address, Write_data, and Write_strb. Load counter with LATENCY and go to WAIT. MemRead&MemWrite together is treated as a write.
- WAIT: if counter==0, go to RAM_RD (reads) or RAM_WR (writes); else decrement. This gives LATENCY+1 WAIT cycles, T+1..T+LATENCY+1.
- RAM_RD (T+LATENCY+2): ram_en=1, ram_wstrb=0, ram_addr=latched address.
- RAM_CAP (T+LATENCY+3): register ram_rdata into Instruction or Read_data.
- RESP (from T+LATENCY+4): Inst_Valid or Read_data_Valid =1 and held with data stable until the matching ack is sampled high, then IDLE. An ack high in the first RESP cycle completes that cycle.
- RAM_WR (T+LATENCY+2): ram_en=1, ram_wstrb=latched strb, ram_wdata=latched data. Then IDLE, so the next accept can occur at T+LATENCY+3. There is no write response.
- Instruction and Read_data hold their last values outside RESP.
- ram_en, ram_wstrb, and ram_wdata are 0 outside RAM_RD and RAM_WR.
- A request that arrives while busy is not acked. It must stay asserted until the block returns to IDLE.
- Ack inputs outside RESP are ignored.

Optional Feature:
- Macro MEM_BRIDGE_PERF_EN.
- Defined: adds outputs inst_stall_cnt[31:0] and data_stall_cnt[31:0].
  - inst_stall_cnt counts every cycle Inst_Req_Valid=1 or the block is servicing a fetch, excluding the Inst_Valid&Inst_Ack cycle.
  - data_stall_cnt does the same for data requests.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports absent, no counter logic.

Test Plan:
- Fetch, LATENCY=2: RAM word 0x004 = 0x00500093; PC=0x10, Inst_Req_Valid=1 -> Inst_Req_Ack at T; ram_en with ram_addr=4 at T+4; Inst_Valid=1 with Instruction=0x00500093 at T+6.
- Backpressure: hold Inst_Ack=0 for 5 cycles in RESP -> Inst_Valid and Instruction stable all 5 cycles; ack on 6th -> IDLE next cycle.
- Byte store: Address=0x20, MemWrite=1, Write_strb=4'b0100, Write_data=0x00AB0000 -> single ram_en cycle at T+4 with ram_addr=8, ram_wstrb=4'b0100; a following load of 0x20 returns a word with byte 2 = 0xAB.
- Priority: Inst_Req_Valid and MemRead high together in IDLE -> Mem_Req_Ack=1, Inst_Req_Ack=0; fetch acked only after Read_data_Ack completes the load.
- Reset mid-access: assert rst=0 during WAIT of a write -> all outputs 0 immediately, no ram_en; after release a fetch completes normally.
- LATENCY=0 sweep: fetch Inst_Valid at T+4, write ram_en at T+2. With MEM_BRIDGE_PERF_EN, one fetch at LATENCY=2 increments inst_stall_cnt by 7.
